key_expansion_ctrl: RTL and testbench

- Sequencer for the AES key-expansion datapath. Covers AES-128, AES-192 and AES-256, selected at run time.
- After `start`, it performs two phases:
  - Load phase: writes the Nk initial key words.
  - Expand phase: issues one word-generation operation per word index until the schedule is complete.
- For each word it drives the datapath with:
  - read addresses for w[i-1] and w[i-Nk];
  - the transform select;
  - the round constant;
  - the write strobe.
- It sits between the cipher top-level control and the round-key store and owns the 6-bit word index.

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/key_index_counter.sv | 31 +++
 rtl/key_expansion_ctrl.sv | 118 +++++++++++
 tb/tb_key_expansion_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length codes, Nk/Nw per length,
// transform selects, sequencer states and the GF(2^8) xtime step.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_ILL = 2'b11
  } key_len_e;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;
  localparam int NW_128 = 44;
  localparam int NW_192 = 52;
  localparam int NW_256 = 60;

  typedef enum logic [1:0] {
    OP_PASS   = 2'b00,
    OP_ROTSUB = 2'b01,
    OP_SUB    = 2'b10
  } op_sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_FIN
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NK_192;
      KL_256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic int nw_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return NW_192;
      KL_256:  return NW_256;
      default: return NW_128;
    endcase
  endfunction

endpackage

// File: rtl/key_index_counter.sv
// Word index i and phase j (i mod Nk) for the key schedule; i saturates at
// the last word index so it never runs past the round-key store.
module key_index_counter
  import aes_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clr,
  input  logic              inc,
  input  logic              adv_phase,
  input  logic [3:0]        nk,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] idx,
  output logic [2:0]        phase
);

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      idx   <= '0;
      phase <= '0;
    end else begin
      if (inc && (idx != last_idx))
        idx <= idx + ADDR_W'(1);
      if (adv_phase)
        phase <= ({1'b0, phase} == (nk - 4'd1)) ? 3'd0 : phase + 3'd1;
    end
  end

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128/192/256 key-expansion sequencer: loads Nk key words, then issues one
// word-generation op per index. Define KEYEXP_ABORT_EN to add the abort input.
module key_expansion_ctrl
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1,
  parameter int ADDR_W   = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  input  logic [1:0]        key_len,
`ifdef KEYEXP_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              load_we,
  output logic [1:0]        op_sel,
  output logic [7:0]        rcon,
  output logic [ADDR_W-1:0] rd_addr_prev,
  output logic [ADDR_W-1:0] rd_addr_back,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  state_e            state, state_nxt;
  logic [3:0]        nk_q;
  logic [ADDR_W-1:0] last_q;
  logic [1:0]        win_q;
  logic              err_q;
  logic [7:0]        rcon_q;
  logic [ADDR_W-1:0] idx;
  logic [2:0]        phase;
  logic              accept, calc_wr, last_wr, kill;
  op_sel_e           op;

`ifdef KEYEXP_ABORT_EN
  assign kill = abort && ((state == S_LOAD) || (state == S_CALC));
`else
  assign kill = 1'b0;
`endif

  assign accept  = (state == S_IDLE) && start && (key_len != KL_ILL);
  assign calc_wr = (state == S_CALC) && (win_q == 2'(SBOX_LAT));
  assign last_wr = calc_wr && (idx == last_q);

  key_index_counter #(.ADDR_W(ADDR_W)) u_idx (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr       ((state == S_IDLE) || kill),
    .inc       ((state == S_LOAD) || calc_wr),
    .adv_phase (calc_wr),
    .nk        (nk_q),
    .last_idx  (last_q),
    .idx       (idx),
    .phase     (phase)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_LOAD;
      S_LOAD: if ((idx + ADDR_W'(1)) == ADDR_W'(nk_q)) state_nxt = S_CALC;
      S_CALC: if (last_wr) state_nxt = S_FIN;
      S_FIN:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  // Window counter stretches each CALC word over SBOX_LAT+1 cycles.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      nk_q   <= '0;
      last_q <= '0;
      win_q  <= '0;
      err_q  <= 1'b0;
      rcon_q <= 8'h01;
    end else begin
      err_q <= (state == S_IDLE) && start && (key_len == KL_ILL);
      if (accept) begin
        nk_q   <= 4'(nk_of(key_len));
        last_q <= ADDR_W'(nw_of(key_len) - 1);
      end
      if ((state != S_CALC) || calc_wr || kill) win_q <= '0;
      else                                      win_q <= win_q + 2'd1;
      if ((state == S_IDLE) || kill)            rcon_q <= 8'h01;
      else if (calc_wr && (op == OP_ROTSUB))    rcon_q <= xtime(rcon_q);
    end
  end

  always_comb begin
    op = OP_PASS;
    if (state == S_CALC) begin
      if (phase == 3'd0)                          op = OP_ROTSUB;
      else if ((nk_q == 4'd8) && (phase == 3'd4)) op = OP_SUB;
    end
  end

  assign busy         = (state == S_LOAD) || (state == S_CALC);
  assign done         = (state == S_FIN);
  assign err          = err_q;
  assign load_we      = (state == S_LOAD);
  assign wr_en        = (state == S_LOAD) || calc_wr;
  assign wr_addr      = busy ? idx : '0;
  assign rd_addr_prev = (state == S_CALC) ? idx - ADDR_W'(1) : '0;
  assign rd_addr_back = (state == S_CALC) ? idx - ADDR_W'(nk_q) : '0;
  assign op_sel       = op;
  assign rcon         = rcon_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed bench for key_expansion_ctrl: one instance with SBOX_LAT=1 driving a
// behavioural key-schedule datapath, one with SBOX_LAT=0 for cycle counts.
module tb_key_expansion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start0;
  logic [1:0] kl1, kl0;
  logic       busy1, done1, err1, lwe1, we1;
  logic       busy0, done0, err0, lwe0, we0;
  logic [1:0] op1, op0;
  logic [7:0] rcon1, rcon0;
  logic [5:0] rp1, rb1, wa1, rp0, rb0, wa0;
`ifdef KEYEXP_ABORT_EN
  logic       abort1 = 1'b0;
  logic       abort0 = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_expansion_ctrl #(.SBOX_LAT(1), .ADDR_W(6)) dut1 (
    .Clk(clk), .Rst(rst), .start(start1), .key_len(kl1),
`ifdef KEYEXP_ABORT_EN
    .abort(abort1),
`endif
    .busy(busy1), .done(done1), .err(err1), .load_we(lwe1), .op_sel(op1),
    .rcon(rcon1), .rd_addr_prev(rp1), .rd_addr_back(rb1), .wr_en(we1),
    .wr_addr(wa1)
  );

  key_expansion_ctrl #(.SBOX_LAT(0), .ADDR_W(6)) dut0 (
    .Clk(clk), .Rst(rst), .start(start0), .key_len(kl0),
`ifdef KEYEXP_ABORT_EN
    .abort(abort0),
`endif
    .busy(busy0), .done(done0), .err(err0), .load_we(lwe0), .op_sel(op0),
    .rcon(rcon0), .rd_addr_prev(rp0), .rd_addr_back(rb0), .wr_en(we0),
    .wr_addr(wa0)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00)
      for (int c = 1; c < 256; c++)
        if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  // Behavioural datapath and write logs for dut1.
  logic [31:0] key1 [0:7];
  logic [31:0] wm1  [0:63];
  logic [5:0]  wlog [$];
  logic [5:0]  ilog [$];
  logic [5:0]  slog [$];
  logic [7:0]  rlog [$];
  int          n_done1 = 0;
  int          n_wr0 = 0, n_sub0 = 0, n_rot0 = 0;

  always @(negedge clk) begin
    logic [31:0] t;
    if (done1) n_done1++;
    if (we1 && !rst) begin
      wlog.push_back(wa1);
      if (lwe1) wm1[wa1] = key1[wa1[2:0]];
      else begin
        t = wm1[rp1];
        if (op1 == 2'b01) begin
          t = subw({t[23:0], t[31:24]}) ^ {rcon1, 24'h0};
          rlog.push_back(rcon1);
          ilog.push_back(wa1);
        end else if (op1 == 2'b10) begin
          t = subw(t);
          slog.push_back(wa1);
        end
        wm1[wa1] = wm1[rb1] ^ t;
      end
    end
    if (we0 && !rst) begin
      n_wr0++;
      if (op0 == 2'b10) n_sub0++;
      if (op0 == 2'b01) n_rot0++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wlog.delete(); ilog.delete(); slog.delete(); rlog.delete();
    n_wr0 = 0; n_sub0 = 0; n_rot0 = 0;
  endtask

  // mode 0: plain run; 1: second start (and key_len change) at CALC i=10;
  // 2: assert Rst at i=20 and return one edge later.
  task automatic run(input bit d, input logic [1:0] kl, input int mode, output int lat);
    int c0;
    bit restarted = 1'b0;
    lat = -1;
    @(negedge clk);
    if (d) begin kl1 = kl; start1 = 1'b1; end
    else   begin kl0 = kl; start0 = 1'b1; end
    c0 = cyc;
    @(negedge clk);
    start1 = 1'b0; start0 = 1'b0;
    chk("busy_after_start", 32'(d ? busy1 : busy0), 32'd1);
    for (int k = 0; k < 300; k++) begin
      start1 = 1'b0;
      if (d ? done1 : done0) begin
        lat = cyc - c0 + 1;
        chk("busy_at_done", 32'(d ? busy1 : busy0), 32'd0);
        break;
      end
      if (mode == 1 && !restarted && we1 && !lwe1 && wa1 == 6'd10) begin
        start1 = 1'b1; kl1 = 2'b10; restarted = 1'b1;
      end
      if (mode == 2 && we1 && wa1 == 6'd20) begin
        rst = 1'b1;
        @(negedge clk);
        lat = -2;
        break;
      end
      @(negedge clk);
    end
    start1 = 1'b0;
  endtask

  initial begin
    int lat;
    int bad;
    logic [7:0] rc [0:9];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    rst = 1'b1; start1 = 1'b0; start0 = 1'b0; kl1 = 2'b00; kl0 = 2'b00;
    key1 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
             32'h0, 32'h0, 32'h0, 32'h0};
    repeat (2) @(negedge clk);
    chk("rst_ctl",  32'({busy1, done1, err1, lwe1, we1, op1}), 32'd0);
    chk("rst_addr", 32'({rp1, rb1, wa1}), 32'd0);
    chk("rst_rcon", 32'(rcon1), 32'h01);
    rst = 1'b0;

    // AES-128 with FIPS-197 key
    clear_logs();
    run(1'b1, 2'b00, 0, lat);
    chk("aes128_latency", 32'(lat), 32'd86);
    chk("aes128_w43", wm1[43], 32'hb6630ca6);
    chk("aes128_writes", 32'(wlog.size()), 32'd44);
    chk("aes128_rcon_cnt", 32'(rlog.size()), 32'd10);
    for (int k = 0; k < 10 && k < rlog.size(); k++)
      chk($sformatf("aes128_rcon%0d", k), 32'(rlog[k]), 32'(rc[k]));

    // AES-256 op_sel / rcon placement
    key1 = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
             32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    clear_logs();
    run(1'b1, 2'b10, 0, lat);
    chk("aes256_latency", 32'(lat), 32'd114);
    chk("aes256_writes", 32'(wlog.size()), 32'd60);
    if (wlog.size() > 0) chk("aes256_last_addr", 32'(wlog[wlog.size()-1]), 32'd59);
    chk("aes256_rot_cnt", 32'(ilog.size()), 32'd7);
    for (int k = 0; k < 7 && k < ilog.size(); k++) begin
      chk($sformatf("aes256_rot_i%0d", k), 32'(ilog[k]), 32'(8 * (k + 1)));
      chk($sformatf("aes256_rcon%0d", k), 32'(rlog[k]), 32'(1 << k));
    end
    chk("aes256_sub_cnt", 32'(slog.size()), 32'd6);
    for (int k = 0; k < 6 && k < slog.size(); k++)
      chk($sformatf("aes256_sub_i%0d", k), 32'(slog[k]), 32'(12 + 8 * k));

    // AES-192 on the zero-latency instance
    clear_logs();
    run(1'b0, 2'b01, 0, lat);
    chk("aes192_latency", 32'(lat), 32'd54);
    chk("aes192_writes", 32'(n_wr0), 32'd52);
    chk("aes192_no_sub", 32'(n_sub0), 32'd0);
    chk("aes192_rot_cnt", 32'(n_rot0), 32'd8);

    // Illegal key length
    @(negedge clk);
    kl1 = 2'b11; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("illegal_err", 32'(err1), 32'd1);
    chk("illegal_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("illegal_err_pulse", 32'(err1), 32'd0);
    chk("illegal_busy_later", 32'(busy1), 32'd0);

    // Second start mid-CALC is ignored
    key1 = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
             32'h0, 32'h0, 32'h0, 32'h0};
    clear_logs();
    run(1'b1, 2'b00, 1, lat);
    chk("restart_latency", 32'(lat), 32'd86);
    chk("restart_writes", 32'(wlog.size()), 32'd44);
    bad = 0;
    for (int k = 0; k < wlog.size(); k++) if (32'(wlog[k]) != 32'(k)) bad++;
    chk("restart_addr_seq", 32'(bad), 32'd0);
    chk("restart_w43", wm1[43], 32'hb6630ca6);

    // Reset at i=20, then a clean re-run
    clear_logs();
    run(1'b1, 2'b00, 2, lat);
    chk("midrst_ctl",  32'({busy1, done1, err1, lwe1, we1, op1}), 32'd0);
    chk("midrst_addr", 32'({rp1, rb1, wa1}), 32'd0);
    chk("midrst_rcon", 32'(rcon1), 32'h01);
    rst = 1'b0;
    clear_logs();
    run(1'b1, 2'b00, 0, lat);
    if (wlog.size() > 0) chk("rerun_first_addr", 32'(wlog[0]), 32'd0);
    chk("rerun_latency", 32'(lat), 32'd86);
    chk("rerun_w43", wm1[43], 32'hb6630ca6);

`ifdef KEYEXP_ABORT_EN
    begin
      int wr_before;
      int dn_before;
      clear_logs();
      @(negedge clk);
      kl1 = 2'b00; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      abort1 = 1'b1;
      @(negedge clk);
      abort1 = 1'b0;
      chk("abort_busy", 32'(busy1), 32'd0);
      chk("abort_rcon", 32'(rcon1), 32'h01);
      wr_before = wlog.size();
      dn_before = n_done1;
      repeat (10) @(negedge clk);
      chk("abort_no_wr", 32'(wlog.size()), 32'(wr_before));
      chk("abort_no_done", 32'(n_done1), 32'(dn_before));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
